multi_target_com: RTL and testbench



---
 rtl/multi_target_com.sv | 203 ++++++++++++++++++++
 tb/tb_multi_target_com.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_target_com.sv
// Purpose : per-frame centre of mass for NUM_TARGETS colour masks, one pass over the pixel stream.
// Latency : valid_out lands 1 + sum_t(1 + found_t*2*(SUM_WIDTH+2)) cycles after an accepted tabulate_in.
// Backpres: none on the pixel stream; tabulate_in while busy_out drops that frame (accumulators still cleared).
// Ports   : clk_in/rst_in (async, active-high); x_in/y_in/valid_in/tabulate_in pixel side;
//           x_out/y_out packed per target, found_out, valid_out pulse, busy_out while the divider runs.
module multi_target_com #(
    parameter int NUM_TARGETS = 2,
    parameter int H_WIDTH     = 11,
    parameter int V_WIDTH     = 10,
    parameter int CNT_WIDTH   = 20,
    parameter int SUM_WIDTH   = 32,
    parameter int MIN_PIXELS  = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [H_WIDTH-1:0]             x_in,
    input  logic [V_WIDTH-1:0]             y_in,
    input  logic [NUM_TARGETS-1:0]         valid_in,
    input  logic                           tabulate_in,
    output logic [NUM_TARGETS*H_WIDTH-1:0] x_out,
    output logic [NUM_TARGETS*V_WIDTH-1:0] y_out,
    output logic [NUM_TARGETS-1:0]         found_out,
    output logic                           valid_out,
    output logic                           busy_out
);

    localparam int TGT_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int STEP_W = $clog2(SUM_WIDTH + 2);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIVX, S_DIVY, S_DONE} state_t;

    state_t state, state_n;

    logic [CNT_WIDTH-1:0] acc_cnt [NUM_TARGETS];
    logic [SUM_WIDTH-1:0] acc_sx  [NUM_TARGETS];
    logic [SUM_WIDTH-1:0] acc_sy  [NUM_TARGETS];
    logic [CNT_WIDTH-1:0] sh_cnt  [NUM_TARGETS];
    logic [SUM_WIDTH-1:0] sh_sx   [NUM_TARGETS];
    logic [SUM_WIDTH-1:0] sh_sy   [NUM_TARGETS];

    logic [H_WIDTH-1:0]     pend_x       [NUM_TARGETS];
    logic [H_WIDTH-1:0]     pend_x_n     [NUM_TARGETS];
    logic [V_WIDTH-1:0]     pend_y       [NUM_TARGETS];
    logic [V_WIDTH-1:0]     pend_y_n     [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] pend_found, pend_found_n;

    logic [TGT_W-1:0]   tgt;
    logic [STEP_W-1:0]  step;
    logic [SUM_WIDTH:0] rem, dvs, trial;
    logic [SUM_WIDTH-1:0] quo;

    logic cnt_ok, last_tgt, div_last;

    function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                     input logic [SUM_WIDTH-1:0] b);
        logic [SUM_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
    endfunction

    assign cnt_ok   = (sh_cnt[tgt] >= CNT_WIDTH'(MIN_PIXELS)) && (sh_cnt[tgt] != '0);
    assign last_tgt = (tgt == TGT_W'(NUM_TARGETS - 1));
    assign div_last = (step == STEP_W'(SUM_WIDTH + 1));
    // Restoring step: shift the next dividend bit into the partial remainder.
    assign trial    = (rem << 1) | (SUM_WIDTH + 1)'(quo[SUM_WIDTH-1]);

    assign valid_out = (state == S_DONE);
    assign busy_out  = (state != S_IDLE);

    // Accumulators and the shadow snapshot. A pixel coinciding with tabulate_in
    // seeds the new frame and never reaches the snapshot.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                acc_cnt[t] <= '0;
                acc_sx[t]  <= '0;
                acc_sy[t]  <= '0;
                sh_cnt[t]  <= '0;
                sh_sx[t]   <= '0;
                sh_sy[t]   <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (tabulate_in) begin
                    if (state == S_IDLE) begin
                        sh_cnt[t] <= acc_cnt[t];
                        sh_sx[t]  <= acc_sx[t];
                        sh_sy[t]  <= acc_sy[t];
                    end
                    acc_cnt[t] <= valid_in[t] ? CNT_WIDTH'(1) : '0;
                    acc_sx[t]  <= valid_in[t] ? SUM_WIDTH'(x_in) : '0;
                    acc_sy[t]  <= valid_in[t] ? SUM_WIDTH'(y_in) : '0;
                end else if (valid_in[t]) begin
                    acc_cnt[t] <= (acc_cnt[t] == '1) ? acc_cnt[t] : acc_cnt[t] + 1'b1;
                    acc_sx[t]  <= sat_add(acc_sx[t], SUM_WIDTH'(x_in));
                    acc_sy[t]  <= sat_add(acc_sy[t], SUM_WIDTH'(y_in));
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (tabulate_in) state_n = S_CHECK;
            S_CHECK: begin
                if (cnt_ok)        state_n = S_DIVX;
                else if (last_tgt) state_n = S_DONE;
                else               state_n = S_CHECK;
            end
            S_DIVX:  if (div_last) state_n = S_DIVY;
            S_DIVY:  if (div_last) state_n = last_tgt ? S_DONE : S_CHECK;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Pending results including this cycle's update, so the commit into the
    // outputs on entry to DONE sees the final store of the last target.
    always_comb begin
        pend_x_n     = pend_x;
        pend_y_n     = pend_y;
        pend_found_n = pend_found;
        if (state == S_CHECK && !cnt_ok)
            pend_found_n[tgt] = 1'b0;
        if (state == S_DIVX && div_last)
            pend_x_n[tgt] = quo[H_WIDTH-1:0];
        if (state == S_DIVY && div_last) begin
            pend_y_n[tgt]     = quo[V_WIDTH-1:0];
            pend_found_n[tgt] = 1'b1;
        end
    end

    // Target index, divider step counter and the shared restoring divider.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tgt  <= '0;
            step <= '0;
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
        end else begin
            if (state == S_IDLE)
                tgt <= '0;
            else if ((state == S_CHECK && !cnt_ok) || (state == S_DIVY && div_last))
                tgt <= tgt + 1'b1;

            if ((state == S_DIVX || state == S_DIVY) && !div_last)
                step <= step + 1'b1;
            else
                step <= '0;

            if (state == S_DIVX || state == S_DIVY) begin
                if (step == '0) begin
                    rem <= '0;
                    quo <= (state == S_DIVX) ? sh_sx[tgt] : sh_sy[tgt];
                    dvs <= (SUM_WIDTH + 1)'(sh_cnt[tgt]);
                end else if (!div_last) begin
                    if (trial >= dvs) begin
                        rem <= trial - dvs;
                        quo <= {quo[SUM_WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= trial;
                        quo <= {quo[SUM_WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

    // Pending registers and the output commit; not-found targets keep their old coordinates.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                pend_x[t] <= '0;
                pend_y[t] <= '0;
            end
            pend_found <= '0;
            x_out      <= '0;
            y_out      <= '0;
            found_out  <= '0;
        end else begin
            pend_x     <= pend_x_n;
            pend_y     <= pend_y_n;
            pend_found <= pend_found_n;
            if (state_n == S_DONE) begin
                found_out <= pend_found_n;
                for (int t = 0; t < NUM_TARGETS; t++) begin
                    if (pend_found_n[t]) begin
                        x_out[t*H_WIDTH +: H_WIDTH] <= pend_x_n[t];
                        y_out[t*V_WIDTH +: V_WIDTH] <= pend_y_n[t];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_target_com.sv
// Purpose : directed self-checking bench for multi_target_com (2 targets, 12-bit counters for a short saturation run).
// Latency : expected valid_out offsets are hand-computed from the tabulate edge.
// Backpres: n/a; the bench drives pixels one per cycle.
module tb_multi_target_com;

    localparam int H = 11;
    localparam int V = 10;

    logic           clk = 1'b0;
    logic           rst_in = 1'b1;
    logic [H-1:0]   x_in = '0;
    logic [V-1:0]   y_in = '0;
    logic [1:0]     valid_in = '0;
    logic           tabulate_in = 1'b0;
    logic [2*H-1:0] x_out;
    logic [2*V-1:0] y_out;
    logic [1:0]     found_out;
    logic           valid_out;
    logic           busy_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_target_com #(
        .NUM_TARGETS(2), .H_WIDTH(H), .V_WIDTH(V),
        .CNT_WIDTH(12), .SUM_WIDTH(32), .MIN_PIXELS(16)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .tabulate_in(tabulate_in),
        .x_out(x_out), .y_out(y_out), .found_out(found_out),
        .valid_out(valid_out), .busy_out(busy_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic px(input int x, input int y, input logic [1:0] v);
        x_in = 11'(x); y_in = 10'(y); valid_in = v; tabulate_in = 1'b0;
        @(posedge clk); #1;
        valid_in = '0;
    endtask

    task automatic tab(input logic [1:0] v, input int x, input int y);
        x_in = 11'(x); y_in = 10'(y); valid_in = v; tabulate_in = 1'b1;
        @(posedge clk); #1;
        valid_in = '0; tabulate_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = '0; tabulate_in = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic block(input int x0, input int y0, input int w, input int h, input logic [1:0] v);
        for (int iy = 0; iy < h; iy++)
            for (int ix = 0; ix < w; ix++)
                px(x0 + ix, y0 + iy, v);
    endtask

    // Cycles (1 = first cycle after the tabulate edge) until valid_out; -1 on timeout.
    task automatic wait_valid(output int lat, output int busy_cnt);
        lat = -1; busy_cnt = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (valid_out) begin lat = k; break; end
            if (busy_out) busy_cnt++;
        end
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        repeat (n) begin @(negedge clk); if (valid_out) c++; end
    endtask

    task automatic check_res(input string tag, input int lat, input int lat_exp,
                             input int x0, input int y0, input int x1, input int y1,
                             input logic [1:0] f);
        check({tag, "_lat"},   lat, lat_exp);
        check({tag, "_x0"},    x_out[H-1:0], x0);
        check({tag, "_y0"},    y_out[V-1:0], y0);
        check({tag, "_x1"},    x_out[2*H-1:H], x1);
        check({tag, "_y1"},    y_out[2*V-1:V], y1);
        check({tag, "_found"}, found_out, f);
    endtask

    int lat, bc, nv;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_found", found_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);
        @(posedge clk); #1; rst_in = 1'b0;
        idle(2);

        // Target 0 only: 16 px at (100,50); target 1 absent -> 1+69+1 = 71
        for (int i = 0; i < 16; i++) px(100, 50, 2'b01);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("single", lat, 71, 100, 50, 0, 0, 2'b01);

        // Two blocks, both found -> 139 cycles, busy 138 cycles before valid
        block(200, 300, 10, 10, 2'b01);
        block(10, 20, 4, 4, 2'b10);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("blocks", lat, 139, 204, 304, 11, 21, 2'b11);
        check("blocks_busy_cnt", bc, 138);
        check("blocks_busy_done", busy_out, 1);
        @(negedge clk);
        check("blocks_valid_single", valid_out, 0);
        check("blocks_busy_after", busy_out, 0);

        // Target 1 with only 15 px -> not found, previous coordinates held
        for (int i = 0; i < 16; i++) px(640, 360, 2'b01);
        for (int i = 0; i < 15; i++) px(500, 400, 2'b10);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("min_gate", lat, 71, 640, 360, 11, 21, 2'b01);

        // Empty frame -> neither found, valid at +3, all coordinates held
        idle(3);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("empty", lat, 3, 640, 360, 11, 21, 2'b00);

        // Overrun: second tabulate 50 cycles after the first, during the division
        idle(2);
        for (int i = 0; i < 16; i++) px(300, 200, 2'b01);
        tab(2'b00, 0, 0);
        for (int i = 0; i < 16; i++) px(700, 100, 2'b01);
        idle(33);
        check("ovr_busy_at_tab", busy_out, 1);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("ovr", lat, 21, 300, 200, 11, 21, 2'b01);
        count_valid(120, nv);
        check("ovr_no_extra_valid", nv, 0);
        for (int i = 0; i < 16; i++) px(50, 60, 2'b01);
        for (int i = 0; i < 16; i++) px(70, 80, 2'b10);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("ovr_next", lat, 139, 50, 60, 70, 80, 2'b11);

        // Pixel in the tabulate cycle belongs to the next frame
        idle(2);
        for (int i = 0; i < 16; i++) px(400, 400, 2'b01);
        tab(2'b01, 1000, 900);
        wait_valid(lat, bc);
        check_res("tabpix_a", lat, 71, 400, 400, 70, 80, 2'b01);
        for (int i = 0; i < 15; i++) px(1000, 900, 2'b01);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("tabpix_b", lat, 71, 1000, 900, 70, 80, 2'b01);

        // Count saturation: 4200 px with a 12-bit counter -> cnt 4095
        // x = floor(4200000/4095) = 1025, y = floor(2100000/4095) = 512
        for (int i = 0; i < 4200; i++) px(1000, 500, 2'b01);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("sat", lat, 71, 1025, 512, 70, 80, 2'b01);

        // Asynchronous reset in the middle of DIVX
        idle(2);
        for (int i = 0; i < 16; i++) px(123, 45, 2'b01);
        tab(2'b00, 0, 0);
        idle(10);
        #2 rst_in = 1'b1;
        #1;
        check("arst_x", x_out, 0);
        check("arst_y", y_out, 0);
        check("arst_found", found_out, 0);
        check("arst_busy", busy_out, 0);
        check("arst_valid", valid_out, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        count_valid(80, nv);
        check("arst_no_valid", nv, 0);
        idle(1);
        for (int i = 0; i < 16; i++) px(321, 99, 2'b10);
        tab(2'b00, 0, 0);
        wait_valid(lat, bc);
        check_res("arst_next", lat, 71, 0, 0, 321, 99, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
